// File: rtl/xor_cipher_pkg.sv
// Shared types and sizing for the XOR cipher controller: state encoding,
// default payload lengths and bit-counter width.
package xor_cipher_pkg;

    localparam int unsigned KEY_BITS_DEF = 32;
    localparam int unsigned MSG_BITS_DEF = 512;
    localparam int unsigned TIMEOUT_DEF  = 1024;
    localparam int unsigned STATE_W      = 3;
    localparam int unsigned CNT_W_DEF    = $clog2(MSG_BITS_DEF) + 1;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD_KEY  = 3'd1,
        ST_LOAD_MSG  = 3'd2,
        ST_ENCRYPT   = 3'd3,
        ST_SERIALIZE = 3'd4,
        ST_DONE      = 3'd5,
        ST_ERROR     = 3'd6
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned msg_bits);
        return $clog2(msg_bits) + 1;
    endfunction

endpackage

// File: rtl/xor_ctrl_watchdog.sv
// Loadable down-counter: load presets LIMIT-1, clear zeroes, hold freezes;
// expired_c is high while the count sits at zero.
module xor_ctrl_watchdog #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic clear,
    input  logic hold,
    output logic expired_c
);

    localparam int unsigned WD_W = $clog2(LIMIT) + 1;

    logic [WD_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = WD_W'(LIMIT - 1);
        end else if (clear) begin
            cnt_d = '0;
        end else if (!hold && (cnt_q != '0)) begin
            cnt_d = cnt_q - WD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/xor_cipher_ctrl.sv
// Frame sequencer for the XOR cipher: routes key then message bits to the
// deserializers, fires encrypt, waits for the serializer. Watchdog: XOR_CTRL_TIMEOUT_EN.
module xor_cipher_ctrl
    import xor_cipher_pkg::*;
#(
    parameter int unsigned KEY_BITS       = KEY_BITS_DEF,
    parameter int unsigned MSG_BITS       = MSG_BITS_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               iStart,
    input  logic               iBit_valid,
    input  logic               iSerial_in,
    input  logic               iEncrypt_done,
    input  logic               iSerial_end,
    output logic               oSerial_data,
    output logic               oLoad_key,
    output logic               oLoad_msg,
    output logic               oEncrypt_go,
    output logic               oBusy,
    output logic               oDone,
    output logic               oError,
    output logic [STATE_W-1:0] oState
);

    localparam int unsigned CNT_W = cnt_width(MSG_BITS);

    if (KEY_BITS == 0 || KEY_BITS > MSG_BITS || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("xor_cipher_ctrl: invalid KEY_BITS/MSG_BITS/TIMEOUT_CYCLES");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             go_pend_q, go_pend_d;
    logic             go_q, go_d;
    logic             sdata_q, sdata_d;
    logic             load_key_q, load_key_d;
    logic             load_msg_q, load_msg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             timeout_c;

`ifdef XOR_CTRL_TIMEOUT_EN
    logic wd_load_c;
    logic wd_clear_c;

    // Restart the wait budget on every state change; only the wait states count.
    assign wd_load_c  = (state_d != state_q);
    assign wd_clear_c = !((state_q == ST_ENCRYPT) || (state_q == ST_SERIALIZE));

    xor_ctrl_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (wd_load_c),
        .clear     (wd_clear_c),
        .hold      (!ena),
        .expired_c (timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    // Next-state, bit counter and strobe generation.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        go_pend_d  = go_pend_q;
        go_d       = 1'b0;
        sdata_d    = sdata_q;
        load_key_d = 1'b0;
        load_msg_d = 1'b0;

        if (ena) begin
            case (state_q)
                ST_IDLE, ST_ERROR: begin
                    if (iStart) begin
                        state_d = ST_LOAD_KEY;
                        cnt_d   = '0;
                    end
                end
                ST_LOAD_KEY: begin
                    if (iBit_valid) begin
                        sdata_d    = iSerial_in;
                        load_key_d = 1'b1;
                        if (cnt_q == CNT_W'(KEY_BITS - 1)) begin
                            cnt_d   = '0;
                            state_d = ST_LOAD_MSG;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_LOAD_MSG: begin
                    if (iBit_valid) begin
                        sdata_d    = iSerial_in;
                        load_msg_d = 1'b1;
                        if (cnt_q == CNT_W'(MSG_BITS - 1)) begin
                            cnt_d     = '0;
                            state_d   = ST_ENCRYPT;
                            go_pend_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_ENCRYPT: begin
                    // go trails the final message strobe by one cycle
                    if (go_pend_q) begin
                        go_d      = 1'b1;
                        go_pend_d = 1'b0;
                    end
                    if (iEncrypt_done) begin
                        state_d = ST_SERIALIZE;
                    end else if (timeout_c) begin
                        state_d = ST_ERROR;
                    end
                end
                ST_SERIALIZE: begin
                    if (iSerial_end) begin
                        state_d = ST_DONE;
                    end else if (timeout_c) begin
                        state_d = ST_ERROR;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d  = !((state_d == ST_IDLE) || (state_d == ST_ERROR));
        done_d  = (state_d == ST_DONE) && (state_q != ST_DONE);
        error_d = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            go_pend_q  <= 1'b0;
            go_q       <= 1'b0;
            sdata_q    <= 1'b0;
            load_key_q <= 1'b0;
            load_msg_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            go_pend_q  <= go_pend_d;
            go_q       <= go_d;
            sdata_q    <= sdata_d;
            load_key_q <= load_key_d;
            load_msg_q <= load_msg_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign oSerial_data = sdata_q;
    assign oLoad_key    = load_key_q;
    assign oLoad_msg    = load_msg_q;
    assign oEncrypt_go  = go_q;
    assign oBusy        = busy_q;
    assign oDone        = done_q;
    assign oError       = error_q;
    assign oState       = state_q;

endmodule

// File: tb/tb_xor_cipher_ctrl.sv
// Scoreboard bench for xor_cipher_ctrl: driver pushes expected strobe/go/done
// events with their due cycle, a negedge monitor pops and compares them.
module tb_xor_cipher_ctrl;

    localparam int KB = 32;
    localparam int MB = 512;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       iStart = 1'b0;
    logic       iBit_valid = 1'b0;
    logic       iSerial_in = 1'b0;
    logic       iEncrypt_done = 1'b0;
    logic       iSerial_end = 1'b0;
    logic       oSerial_data, oLoad_key, oLoad_msg, oEncrypt_go;
    logic       oBusy, oDone, oError;
    logic [2:0] oState;

    xor_cipher_ctrl #(
        .KEY_BITS       (KB),
        .MSG_BITS       (MB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ena           (ena),
        .iStart        (iStart),
        .iBit_valid    (iBit_valid),
        .iSerial_in    (iSerial_in),
        .iEncrypt_done (iEncrypt_done),
        .iSerial_end   (iSerial_end),
        .oSerial_data  (oSerial_data),
        .oLoad_key     (oLoad_key),
        .oLoad_msg     (oLoad_msg),
        .oEncrypt_go   (oEncrypt_go),
        .oBusy         (oBusy),
        .oDone         (oDone),
        .oError        (oError),
        .oState        (oState)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kind;   // 1 key strobe, 2 msg strobe, 3 encrypt go, 4 done
        bit b;
        int c;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  n_key = 0;
    int  n_msg = 0;
    int  ena_low_left = 0;
    int  gap_mode = 0;
    bit  valid_phase = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic pop_chk(input int kind, input logic b);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event kind=%0d actual_cycle=%0d required=none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_bit", int'(b), int'(e.b));
            chk("event_cycle", cyc, e.c);
        end
    endtask

    // Monitor: every strobe/go/done the DUT shows must match the next expected event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (oLoad_key) begin
                n_key++;
                pop_chk(1, oSerial_data);
            end
            if (oLoad_msg) begin
                n_msg++;
                pop_chk(2, oSerial_data);
            end
            if (oEncrypt_go) pop_chk(3, 1'b0);
            if (oDone) pop_chk(4, 1'b0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, int'({oSerial_data, oLoad_key, oLoad_msg, oEncrypt_go,
                        oBusy, oDone, oError, oState}), 0);
    endtask

    // Present one payload bit until the model says it was accepted (valid && ena).
    task automatic send_bit(input int kind, input bit b);
        bit taken = 1'b0;
        while (!taken) begin
            if (ena_low_left > 0) begin
                ena = 1'b0;
                ena_low_left--;
            end else begin
                ena = 1'b1;
            end
            case (gap_mode)
                1:       valid_phase = ~valid_phase;
                2:       valid_phase = 1'($urandom_range(0, 1));
                default: valid_phase = 1'b1;
            endcase
            iBit_valid = valid_phase;
            iSerial_in = valid_phase ? b : 1'($urandom_range(0, 1));
            if (ena && iBit_valid) begin
                exp_q.push_back('{kind, b, cyc + 1});
                taken = 1'b1;
            end
            tick();
        end
        iBit_valid = 1'b0;
        ena = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        chk("queue_drained_before_reset", exp_q.size(), 0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_reset_outputs");
        tick();
        chk_all_zero("reset_held_outputs");
        exp_q.delete();
        n_key = 0;
        n_msg = 0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic run_frame(input logic [31:0] key, input int gap, input int ena_low_at,
                             input bit timeout_mode);
        logic [31:0] k;
        k = key;
        gap_mode = gap;
        ena = 1'b1;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        chk("start_state", int'(oState), 1);
        chk("start_busy", int'(oBusy), 1);
        for (int i = 0; i < KB; i++) begin
            if (i == ena_low_at) ena_low_left = 10;
            iStart = (i == 3);
            send_bit(1, k[31-i]);
        end
        iStart = 1'b0;
        for (int j = 0; j < MB; j++) begin
            send_bit(2, 1'($urandom_range(0, 1)));
        end
        // last message strobe is visible now; go follows one cycle later
        exp_q.push_back('{3, 1'b0, cyc + 1});
        if (timeout_mode) begin
            repeat (TO - 1) tick();
            chk("timeout_still_encrypt", int'(oState), 3);
            tick();
            chk("timeout_error_state", int'(oState), 6);
            chk("timeout_error_flag", int'(oError), 1);
            chk("timeout_not_busy", int'(oBusy), 0);
            iStart = 1'b1;
            tick();
            iStart = 1'b0;
            chk("error_restart_state", int'(oState), 1);
            chk("error_restart_flag", int'(oError), 0);
            do_reset();
            return;
        end
        tick();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        chk("encrypt_ignores_start", int'(oState), 3);
        repeat (5) tick();
        iEncrypt_done = 1'b1;
        tick();
        iEncrypt_done = 1'b0;
        chk("serialize_state", int'(oState), 4);
        repeat (519) tick();
        iSerial_end = 1'b1;
        exp_q.push_back('{4, 1'b0, cyc + 1});
        tick();
        iSerial_end = 1'b0;
        chk("done_state", int'(oState), 5);
        chk("done_busy", int'(oBusy), 1);
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        chk("after_done_idle", int'(oState), 0);
        chk("after_done_not_busy", int'(oBusy), 0);
        chk("key_strobes", n_key, KB);
        chk("msg_strobes", n_msg, MB);
        chk("queue_empty", exp_q.size(), 0);
        n_key = 0;
        n_msg = 0;
    endtask

    initial begin
        logic [31:0] rkey;
        repeat (2) tick();
        chk_all_zero("power_on_reset");
        rst_n = 1'b1;
        ena = 1'b1;
        tick();

        // Bits offered while idle must produce no strobes.
        iBit_valid = 1'b1;
        repeat (4) begin
            iSerial_in = 1'($urandom_range(0, 1));
            tick();
        end
        iBit_valid = 1'b0;
        chk("idle_ignores_bits", int'(oState), 0);

        // Abort mid-message with reset, then a full frame must work from scratch.
        gap_mode = 0;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        for (int i = 0; i < KB; i++) send_bit(1, 1'($urandom_range(0, 1)));
        for (int j = 0; j < 100; j++) send_bit(2, 1'($urandom_range(0, 1)));
        chk("mid_load_state", int'(oState), 2);
        do_reset();
        chk("post_reset_state", int'(oState), 0);

        run_frame(32'hA5A5_A5A5, 0, -1, 1'b0);
        run_frame(32'hA5A5_A5A5, 1, 12, 1'b0);
        rkey = $urandom;
        run_frame(rkey, 2, 5, 1'b0);
`ifdef XOR_CTRL_TIMEOUT_EN
        rkey = $urandom;
        run_frame(rkey, 0, -1, 1'b1);
`endif

        repeat (3) tick();
        chk("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
